bus_device_fifo: RTL and testbench
==================================

Name: bus_device_fifo

Overview:
- Per-device transmit FIFO sitting directly upstream of the bus generator/arbiter (bs_gnrtr_n_rbtr); one instance per device port.
- Device side (driver) pushes packets; bus side sees `pndng` and the head packet on `D_pop`, and asserts `pop` to consume it.
- First-word-fall-through buffering with full/empty flags, occupancy count, non-power-of-2 depth wrap, and single-cycle error pulses.
- Filters illegal self-addressed packets at push.

Parameters:
- pckg_sz, 16, packet width in bits; bits [pckg_sz-1 -: 8] hold the destination ID.
- depth, 12, number of entries; any value >= 2, not necessarily a power of 2.
- id, 0, this device's 8-bit ID, used for self-address filtering.
- broadcast, 8'hFF, destination ID meaning "all devices"; always accepted.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- push  in  1  device requests write of D_push this cycle.
- D_push  in  pckg_sz  packet to write.
- pop  in  1  bus consumes head entry this cycle.
- D_pop  out  pckg_sz  head packet, valid when pndng=1.
- pndng  out  1  FIFO non-empty.
- full  out  1  count == depth.
- count  out  $clog2(depth+1)  current occupancy.
- overflow  out  1  one-cycle pulse: push rejected because full.
- underflow  out  1  one-cycle pulse: pop while empty.
- self_err  out  1  one-cycle pulse: push rejected because destination == id.

Behaviour:
- Reset (reset=0, async assert, sync deassert by clk edge): wr_ptr=0, rd_ptr=0, count=0, pndng=0, full=0, overflow=0, underflow=0, self_err=0. D_pop=0. Storage contents are don't-care.
- Reset mid-operation flushes all entries immediately; no pulse outputs are generated by the flush.
- Storage is a depth-entry register array.
  - Pointers increment modulo depth: the value depth-1 wraps to 0, with an explicit compare, not bit truncation.
- D_pop = mem[rd_ptr] combinationally when count>0, else 0.
  - Zero-latency FWFT: a packet pushed at edge N is visible on D_pop with pndng=1 after edge N.
- Push acceptance, evaluated at the rising edge. A push is accepted iff all of:
  - push=1;
  - destination != id, or destination == broadcast;
  - not (full and pop=0).
- On acceptance: mem[wr_ptr] <= D_push; wr_ptr advances.
- Self-addressed push: dropped; self_err=1 for the next cycle; takes priority over overflow when both apply.
- Push while full with pop=0: dropped; overflow=1 for the next cycle.
- Push while full with pop=1: both accepted; count stays depth; full stays 1.
- Pop acceptance: pop=1 and count>0 → rd_ptr advances.
- Pop with count=0 → ignored; underflow=1 for the next cycle.
  - This applies even if push=1 in the same cycle: no bypass, and the pushed packet is still written.
- Simultaneous accepted push and pop with 0<count<depth → count unchanged; both pointers advance.
- count update: +1 on push only, -1 on pop only, else hold.
  - pndng = (count != 0); full = (count == depth); both registered consistently with count.
- Error pulses are high for exactly one cycle per offending edge; consecutive offending cycles give consecutive highs.
- Ordering is strictly FIFO. No packet is modified; the broadcast packet is stored unchanged.

Test Plan:
- Reset and basic FWFT: id=3. Assert reset=0, then release. Push 16'h0512 → next cycle pndng=1, D_pop=16'h0512, count=1. Pop → pndng=0, count=0, D_pop=0.
- Fill and overflow: push 12 packets 16'h0100..16'h010B → full=1, count=12. Push 16'h0177 with pop=0 → overflow pulses once, count stays 12. Pop all 12 → data returned in order 0100..010B; 0177 never appears.
- Wrap-around at depth 12: push 8, pop 8, push 10 (pointers wrap 11→0). Pop 10 → exact order preserved, count returns to 0.
- Full with simultaneous push/pop: at count=12, push 16'h02AA with pop=1 → head removed, 02AA appended, count=12, full=1, no overflow. 02AA is the last popped.
- Self-address and broadcast filtering (id=3): push 16'h03CC → self_err pulses, count unchanged. Push 16'hFF55 → accepted, D_pop=16'hFF55.
- Underflow and async reset mid-stream:
  - With empty FIFO, pop=1 and push 16'h0411 together → underflow pulses; count=1; D_pop=16'h0411.
  - Then push 5 more packets and drop reset asynchronously mid-cycle → all outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/bus_device_fifo.sv
// Purpose: per-device transmit FIFO feeding the bus arbiter; filters self-addressed packets at push.
// Latency: first-word-fall-through, a packet pushed at edge N is on D_pop with pndng=1 right after edge N.
// Backpressure: full stalls pushes (overflow pulse) unless the same cycle pops; pop when empty gives underflow.
module bus_device_fifo #(
  parameter int          pckg_sz   = 16,
  parameter int          depth     = 12,
  parameter logic [7:0]  id        = 8'h00,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  input  logic                       pop,
  output logic [pckg_sz-1:0]         D_pop,
  output logic                       pndng,
  output logic                       full,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       self_err
);

  localparam int cw = $clog2(depth + 1);
  localparam int pw = $clog2(depth);

  logic [pckg_sz-1:0] mem [depth];
  logic [pw-1:0]      wr_ptr;
  logic [pw-1:0]      rd_ptr;
  logic [pw-1:0]      wr_ptr_nxt;
  logic [pw-1:0]      rd_ptr_nxt;
  logic [cw-1:0]      count_nxt;

  logic [7:0] dest;
  logic       self_hit;
  logic       push_ok;
  logic       pop_ok;
  logic       ovf_hit;
  logic       udf_hit;

  // A broadcast destination always passes, even if it happens to equal our own id.
  assign dest     = D_push[pckg_sz-1 -: 8];
  assign self_hit = push && (dest == id) && (dest != broadcast);
  // When full, a same-cycle pop frees the slot the push needs.
  assign push_ok  = push && !self_hit && !(full && !pop);
  assign ovf_hit  = push && !self_hit && full && !pop;
  assign pop_ok   = pop && pndng;
  assign udf_hit  = pop && !pndng;

  // Head entry is shown only while occupied so an empty FIFO presents zero.
  assign D_pop = pndng ? mem[rd_ptr] : '0;

  // Pointer advance and occupancy bookkeeping; depth need not be a power of two,
  // so the wrap is an explicit compare against the last index.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (push_ok) begin
      wr_ptr_nxt = (wr_ptr == pw'(depth - 1)) ? '0 : wr_ptr + pw'(1);
    end
    if (pop_ok) begin
      rd_ptr_nxt = (rd_ptr == pw'(depth - 1)) ? '0 : rd_ptr + pw'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + cw'(1);
      2'b01:   count_nxt = count - cw'(1);
      default: count_nxt = count;
    endcase
  end

  // Control state and single-cycle error pulses; reset flushes without pulsing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pndng     <= 1'b0;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      self_err  <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      pndng     <= (count_nxt != '0);
      full      <= (count_nxt == cw'(depth));
      overflow  <= ovf_hit;
      underflow <= udf_hit;
      self_err  <= self_hit;
    end
  end

  // Packet storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= D_push;
    end
  end

endmodule

// File: tb/tb_bus_device_fifo.sv
module tb_bus_device_fifo;

  localparam int         DEPTH = 12;
  localparam logic [7:0] ID    = 8'h03;
  localparam logic [7:0] BC    = 8'hFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push = 1'b0;
  logic [15:0] D_push = '0;
  logic        pop = 1'b0;
  logic [15:0] D_pop;
  logic        pndng;
  logic        full;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;
  logic        self_err;

  int tests = 0;
  int fails = 0;

  // Reference model: an ordered list of stored packets plus the expected pulses.
  logic [15:0] q[$];
  logic        e_ovf, e_udf, e_self;

  bus_device_fifo #(.pckg_sz(16), .depth(DEPTH), .id(ID), .broadcast(BC)) dut (
    .clk(clk), .reset(reset), .push(push), .D_push(D_push), .pop(pop),
    .D_pop(D_pop), .pndng(pndng), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow), .self_err(self_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic [15:0] d;
    logic        pop;
    logic [3:0]  cnt;
    logic        pnd;
    logic        ful;
    logic [15:0] dq;
    logic        ovf;
    logic        udf;
    logic        se;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " count"}, 32'(count), 32'(q.size()));
    chk({tag, " pndng"}, 32'(pndng), 32'(q.size() != 0));
    chk({tag, " full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({tag, " D_pop"}, 32'(D_pop), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    chk({tag, " overflow"}, 32'(overflow), 32'(e_ovf));
    chk({tag, " underflow"}, 32'(underflow), 32'(e_udf));
    chk({tag, " self_err"}, 32'(self_err), 32'(e_self));
  endtask

  // One clock of stimulus; the model is advanced from the pre-edge occupancy.
  task automatic step(input logic p, input logic [15:0] d, input logic pp, input string tag);
    logic is_self, pop_ok, push_ok;
    int   sz;
    push   = p;
    D_push = d;
    pop    = pp;
    sz      = q.size();
    is_self = p && (d[15:8] == ID) && (d[15:8] != BC);
    pop_ok  = pp && (sz > 0);
    push_ok = p && !is_self && !(sz == DEPTH && !pp);
    e_self  = is_self;
    e_ovf   = p && !is_self && (sz == DEPTH) && !pp;
    e_udf   = pp && (sz == 0);
    if (pop_ok) void'(q.pop_front());
    if (push_ok) q.push_back(d);
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    check_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    q.delete();
    e_ovf = 1'b0; e_udf = 1'b0; e_self = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_d;
    vt[0] = '{1'b1, 16'h0512, 1'b0, 4'd1, 1'b1, 1'b0, 16'h0512, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 16'h0000, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 16'h03CC, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vt[3] = '{1'b1, 16'hFF55, 1'b0, 4'd1, 1'b1, 1'b0, 16'hFF55, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b0, 16'h0000, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b1, 16'h0411, 1'b1, 4'd1, 1'b1, 1'b0, 16'h0411, 1'b0, 1'b1, 1'b0};
    vt[6] = '{1'b0, 16'h0000, 1'b0, 4'd1, 1'b1, 1'b0, 16'h0411, 1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b0, 16'h0000, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vt[8] = '{1'b1, 16'h0312, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
    vt[9] = '{1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

    e_ovf = 1'b0; e_udf = 1'b0; e_self = 1'b0;

    // Reset state while held in reset.
    reset = 1'b0;
    #12;
    chk("rst count", 32'(count), 32'h0);
    chk("rst pndng", 32'(pndng), 32'h0);
    chk("rst full", 32'(full), 32'h0);
    chk("rst D_pop", 32'(D_pop), 32'h0);
    chk("rst pulses", {29'h0, overflow, underflow, self_err}, 32'h0);
    do_reset();

    // Directed vectors: FWFT, self filter, broadcast, underflow with push.
    for (int i = 0; i < 10; i++) begin
      push = vt[i].push; D_push = vt[i].d; pop = vt[i].pop;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0;
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vt[i].cnt));
      chk($sformatf("vec%0d pndng", i), 32'(pndng), 32'(vt[i].pnd));
      chk($sformatf("vec%0d full", i), 32'(full), 32'(vt[i].ful));
      chk($sformatf("vec%0d D_pop", i), 32'(D_pop), 32'(vt[i].dq));
      chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vt[i].ovf));
      chk($sformatf("vec%0d underflow", i), 32'(underflow), 32'(vt[i].udf));
      chk($sformatf("vec%0d self_err", i), 32'(self_err), 32'(vt[i].se));
    end

    // Fill and overflow.
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, "fill");
    chk("fill full", 32'(full), 32'h1);
    step(1'b1, 16'h0177, 1'b0, "ovf push");
    chk("ovf pulse", 32'(overflow), 32'h1);
    chk("ovf count", 32'(count), 32'd12);
    step(1'b0, 16'h0, 1'b0, "ovf idle");
    for (int i = 0; i < 12; i++) begin
      exp_d = 16'h0100 + 16'(i);
      chk("drain order", 32'(D_pop), 32'(exp_d));
      step(1'b0, 16'h0, 1'b1, "drain");
    end

    // Pointer wrap at a non-power-of-two depth.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0500 + 16'(i), 1'b0, "wrap push8");
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 1'b1, "wrap pop8");
    for (int i = 0; i < 10; i++) step(1'b1, 16'h0600 + 16'(i), 1'b0, "wrap push10");
    for (int i = 0; i < 10; i++) begin
      exp_d = 16'h0600 + 16'(i);
      chk("wrap order", 32'(D_pop), 32'(exp_d));
      step(1'b0, 16'h0, 1'b1, "wrap pop10");
    end
    chk("wrap empty", 32'(count), 32'h0);

    // Full with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0, "fp fill");
    step(1'b1, 16'h02AA, 1'b1, "fp pushpop");
    chk("fp count", 32'(count), 32'd12);
    chk("fp full", 32'(full), 32'h1);
    chk("fp no ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < 12; i++) begin
      exp_d = (i == 11) ? 16'h02AA : 16'h0201 + 16'(i);
      chk("fp order", 32'(D_pop), 32'(exp_d));
      step(1'b0, 16'h0, 1'b1, "fp drain");
    end

    // Underflow with push, then asynchronous reset mid-cycle.
    do_reset();
    step(1'b1, 16'h0411, 1'b1, "udf push");
    chk("udf pulse", 32'(underflow), 32'h1);
    chk("udf D_pop", 32'(D_pop), 32'h0411);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0420 + 16'(i), 1'b0, "pre-rst");
    #2;
    reset = 1'b0;
    #1;
    chk("arst count", 32'(count), 32'h0);
    chk("arst pndng", 32'(pndng), 32'h0);
    chk("arst full", 32'(full), 32'h0);
    chk("arst D_pop", 32'(D_pop), 32'h0);
    chk("arst pulses", {29'h0, overflow, underflow, self_err}, 32'h0);
    do_reset();

    // Randomized traffic against the queue model, phases biased toward full and empty.
    for (int ph = 0; ph < 4; ph++) begin
      int push_pct;
      int pop_pct;
      push_pct = (ph % 2 == 0) ? 80 : 25;
      pop_pct  = (ph % 2 == 0) ? 30 : 75;
      for (int c = 0; c < 500; c++) begin
        logic        p, pp;
        logic [15:0] d;
        int          sel;
        p   = ($urandom_range(0, 99) < push_pct);
        pp  = ($urandom_range(0, 99) < pop_pct);
        sel = $urandom_range(0, 9);
        d[7:0]  = 8'($urandom);
        d[15:8] = (sel < 2) ? ID : (sel == 2) ? BC : 8'($urandom);
        step(p, d, pp, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
